des_key_schedule_seq: RTL and testbench
=======================================

Name: des_key_schedule_seq

Overview:
Sequential DES key schedule. It accepts a 64-bit key and applies PC-1, then rotates the C/D halves round by round. It streams the sixteen 48-bit PC-2 subkeys out over a valid/ready handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). It sits downstream of the key input register and feeds the round-function datapath one subkey per round, replacing per-round combinational shift trees.

Parameters:
ALLOW_RESTART, 0, 1 = i_start while busy aborts the current schedule and reloads; 0 = i_start ignored while busy
DONE_PULSE, 1, 1 = o_done is a one-cycle pulse; 0 = o_done stays high until next i_start

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  load i_key/i_decrypt and begin schedule (sampled when accepted)
i_key  input  64  DES key, bit 63 = DES bit 1; parity bits (8,16,..64) ignored
i_decrypt  input  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1
o_busy  output  1  schedule in progress
o_valid  output  1  o_subkey/o_round valid
i_ready  input  1  consumer accepts subkey this cycle
o_subkey  output  48  PC-2 of current C/D, bit 47 = PC-2 output bit 1
o_round  output  4  index of subkey in issue order, 0..15
o_done  output  1  all 16 subkeys accepted

Behaviour:
- Clock/reset: one clock i_clk; reset i_rst_n asynchronous, active-low. On assertion: state IDLE, C/D = 0, round counter = 0, o_busy/o_valid/o_done = 0. o_subkey then equals PC-2(0) = 0, and o_round = 0.
- States: IDLE, ISSUE, DONE. DONE exists only when DONE_PULSE = 0; otherwise the block returns straight to IDLE.
- IDLE, i_start = 1 at edge T:
  - C/D <= PC-1(i_key); encrypt additionally rotates left by 1 (K1's shift). Decrypt uses no rotate, since K16 = PC-2(PC-1(key)) after a total shift of 28.
  - Latch dir <= i_decrypt; counter <= 0; go to ISSUE.
  - o_valid and o_busy are high from T+1, so the first subkey appears one cycle after start.
- ISSUE:
  - o_valid = 1.
  - o_subkey = PC-2(C/D), purely combinational from registers, no extra latency.
  - o_round = counter.
- Handshake: transfer on o_valid and i_ready at a rising edge.
  - o_subkey and o_round are held stable while o_valid = 1 and i_ready = 0.
  - i_ready with o_valid = 0 has no effect.
- On transfer with counter r < 15:
  - counter <= r+1.
  - Encrypt: rotate C and D left by SHIFT[r+1].
  - Decrypt: rotate C and D right by SHIFT[15-r].
  - SHIFT[i] = 1 for i in {0,1,8,15}, else 2; C and D rotate independently, 28 bits each.
  - With i_ready held high, one subkey issues per cycle: 16 subkeys in 16 cycles after the first valid.
- On transfer with r = 15: o_valid <= 0, o_busy <= 0, o_done <= 1.
  - DONE_PULSE = 1: o_done stays high one cycle; state becomes IDLE.
  - DONE_PULSE = 0: state becomes DONE; o_done stays high until the next accepted i_start, which clears it and loads.
- i_start while busy:
  - ALLOW_RESTART = 0: ignored, no state change.
  - ALLOW_RESTART = 1: reload as in IDLE (counter 0, new key/dir), with o_valid staying high. A transfer in the same cycle is discarded because the restart wins. No o_done is emitted for the aborted schedule.
- i_start in the same cycle as the final (r = 15) transfer: with ALLOW_RESTART = 1, the restart wins and o_done is not asserted. With ALLOW_RESTART = 0, the final transfer completes and i_start is ignored.
- Reset mid-schedule: asynchronous return to the reset values above; the partial schedule is lost.
- Counter arithmetic is 4-bit unsigned and never wraps; issue stops at 15.

Decomposition:
- Package des_pkg:
  - PC1 table (56 entries) and PC2 table (48 entries) as constant index arrays.
  - SHIFT schedule constant, 16 × 2 bits.
  - State enum {IDLE, ISSUE, DONE}.
  - Width constants: KEY_W = 64, CD_W = 56, SUBKEY_W = 48.
- Sub-module des_pc2_permute: combinational 56→48 PC-2, shared with other DES blocks.
- PC-1 is applied inline at load; it is not instantiated as a separate sub-module.

Test Plan:
- Encrypt, i_ready = 1, key 64'h133457799BBCDFF1 -> round 0 = 48'h1B02EFFC7072, round 1 = 48'h79AED9DBC9E5, round 15 = 48'hCB3D8B0E17F5. o_done pulses the cycle after the round-15 transfer (DONE_PULSE = 1).
- Decrypt, same key -> round 0 = 48'hCB3D8B0E17F5, round 14 = 48'h79AED9DBC9E5, round 15 = 48'h1B02EFFC7072. The full decrypt sequence equals the encrypt sequence reversed.
- Backpressure: i_ready random ~50%, encrypt -> o_subkey/o_round stable during stalls; exactly 16 transfers with o_round 0..15 in order; no duplicates.
- Key 64'h0, then 64'hFFFFFFFFFFFFFFFF -> all 16 subkeys are 48'h0, then all 48'hFFFFFFFFFFFF; parity-bit toggles in i_key do not change any subkey.
- i_start at round 5 -> ALLOW_RESTART = 0: sequence continues unchanged. ALLOW_RESTART = 1: next valid is round 0 of the new key, with no o_done for the aborted schedule.
- Deassert i_rst_n mid-schedule at round 7 -> o_valid/o_busy/o_done go 0 immediately (asynchronously); after release, a new i_start yields a correct round-0 subkey.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, shift schedule,
// FSM state type and the small bit-shuffling helpers used at load and per round.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  // PC-1: entry i names the DES key bit (1 = MSB) that becomes C/D bit i+1.
  localparam int PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry i names the C/D bit (1 = MSB) that becomes subkey bit i+1.
  localparam int PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Per-round left-rotate amount; SHIFT[i] is applied to produce K(i+1).
  localparam logic [1:0] SHIFT [ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Gather the 56 non-parity key bits into C (upper half) and D (lower half).
  function automatic logic [CD_W-1:0] pc1_permute(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < CD_W; i++) begin
      cd[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1_TBL[i])];
    end
    return cd;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0]        n);
    return (n == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                       : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0]        n);
    return (n == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                       : {x[0], x[HALF_W-1:1]};
  endfunction

  // C and D rotate independently; they never exchange bits.
  function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] cd,
                                              input logic [1:0]      n);
    return {rotl28(cd[CD_W-1:HALF_W], n), rotl28(cd[HALF_W-1:0], n)};
  endfunction

  function automatic logic [CD_W-1:0] rotr_cd(input logic [CD_W-1:0] cd,
                                              input logic [1:0]      n);
    return {rotr28(cd[CD_W-1:HALF_W], n), rotr28(cd[HALF_W-1:0], n)};
  endfunction

endpackage

// File: rtl/des_pc2_permute.sv
// Combinational PC-2 compression of a 56-bit C/D pair into a 48-bit subkey.
module des_pc2_permute
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     i_cd,
  output logic [SUBKEY_W-1:0] o_subkey
);

  // Pure wiring: each subkey bit selects one C/D bit.
  always_comb begin
    o_subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      o_subkey[6'(SUBKEY_W - 1 - i)] = i_cd[6'(CD_W - PC2_TBL[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule_seq.sv
// Sequential DES key schedule: loads PC-1 of the key, then rotates C/D one
// round per accepted subkey and streams PC-2 subkeys over valid/ready, in
// encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule_seq
  import des_pkg::*;
#(
  parameter bit ALLOW_RESTART = 1'b0,
  parameter bit DONE_PULSE    = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [KEY_W-1:0]    i_key,
  input  logic                i_decrypt,
  output logic                o_busy,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SUBKEY_W-1:0] o_subkey,
  output logic [3:0]          o_round,
  output logic                o_done
);

  state_e          state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [CD_W-1:0] cd_pc1, cd_load;
  logic [3:0]      cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;
  logic            load;

  // Load value: encrypt starts at K1 (one left shift); decrypt starts at K16,
  // whose cumulative shift of 28 returns C/D to plain PC-1.
  always_comb begin
    cd_pc1  = pc1_permute(i_key);
    cd_load = i_decrypt ? cd_pc1 : rotl_cd(cd_pc1, SHIFT[0]);
  end

  // Next-state, handshake and round advance; a restart overrides any transfer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = DONE_PULSE ? 1'b0 : done_q;
    load    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        load = i_start;
      end
      ISSUE: begin
        if (i_start && ALLOW_RESTART) begin
          load = 1'b1;
        end else if (i_ready) begin
          if (cnt_q == 4'd15) begin
            state_d = DONE_PULSE ? IDLE : DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            cd_d  = dir_q ? rotr_cd(cd_q, SHIFT[4'd15 - cnt_q])
                          : rotl_cd(cd_q, SHIFT[cnt_q + 4'd1]);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = ISSUE;
      cd_d    = cd_load;
      cnt_d   = 4'd0;
      dir_d   = i_decrypt;
      done_d  = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, regardless of statement order.
    if (!i_rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      cnt_q   <= 4'd0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  des_pc2_permute u_pc2 (
    .i_cd     (cd_q),
    .o_subkey (o_subkey)
  );

  // Outputs come straight from registers.
  always_comb begin
    o_valid = (state_q == ISSUE);
    o_busy  = (state_q == ISSUE);
    o_round = cnt_q;
    o_done  = done_q;
  end

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Self-checking bench: instance A uses default parameters, instance B uses
// ALLOW_RESTART = 1 and DONE_PULSE = 0. Both share all inputs.
module tb_des_key_schedule_seq;

  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_decrypt, i_ready;
  logic [63:0] i_key;
  logic        busy_a, valid_a, done_a, busy_b, valid_b, done_b;
  logic [47:0] sub_a, sub_b;
  logic [3:0]  round_a, round_b;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [47:0] got [16];

  always #5 clk = ~clk;

  des_key_schedule_seq u_dut_a (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (i_start), .i_key (i_key),
    .i_decrypt (i_decrypt), .o_busy (busy_a), .o_valid (valid_a),
    .i_ready (i_ready), .o_subkey (sub_a), .o_round (round_a), .o_done (done_a)
  );

  des_key_schedule_seq #(.ALLOW_RESTART(1'b1), .DONE_PULSE(1'b0)) u_dut_b (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (i_start), .i_key (i_key),
    .i_decrypt (i_decrypt), .o_busy (busy_b), .o_valid (valid_b),
    .i_ready (i_ready), .o_subkey (sub_b), .o_round (round_b), .o_done (done_b)
  );

  // Reference subkey Kk (k = 1..16) from DES bit numbering and total shift.
  function automatic logic [47:0] ref_key(input logic [63:0] key, input int k);
    int          total;
    bit          cd  [56];
    bit          rot [56];
    logic [47:0] s;
    total = 0;
    for (int i = 0; i < k; i++) total += SHIFTS[i];
    for (int i = 0; i < 56; i++) cd[i] = key[64 - PC1_T[i]];
    for (int i = 0; i < 28; i++) begin
      rot[i]      = cd[(i + total) % 28];
      rot[28 + i] = cd[28 + (i + total) % 28];
    end
    for (int j = 0; j < 48; j++) s[47 - j] = rot[PC2_T[j] - 1];
    return s;
  endfunction

  function automatic logic [47:0] exp_sub(input logic [63:0] key, input bit dec,
                                          input int idx);
    return dec ? ref_key(key, 16 - idx) : ref_key(key, idx + 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] key, input bit dec);
    i_key     = key;
    i_decrypt = dec;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
  endtask

  // Run one full schedule on both instances in lockstep, capturing A's subkeys.
  task automatic run_sched(input logic [63:0] key, input bit dec, input bit rnd_ready);
    int          idx = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [47:0] prev_k = '0;
    logic [3:0]  prev_r = '0;
    i_ready = 1'b0;
    start(key, dec);
    while (idx < 16 && cyc < 400) begin
      check("a_valid", valid_a, 1);
      check("b_valid", valid_b, 1);
      check("a_busy", busy_a, 1);
      check("a_round", round_a, idx);
      check("b_round", round_b, idx);
      check("a_subkey", sub_a, exp_sub(key, dec, idx));
      check("b_subkey", sub_b, exp_sub(key, dec, idx));
      if (stalled) begin
        check("stall_subkey", sub_a, prev_k);
        check("stall_round", round_a, prev_r);
      end
      got[idx] = sub_a;
      prev_k   = sub_a;
      prev_r   = round_a;
      i_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled  = !i_ready;
      tick();
      if (i_ready) idx++;
      cyc++;
    end
    i_ready = 1'b0;
    check("sched_transfers", idx, 16);
    check("a_done_pulse", done_a, 1);
    check("b_done_set", done_b, 1);
    check("a_valid_end", valid_a, 0);
    check("a_busy_end", busy_a, 0);
    check("b_valid_end", valid_b, 0);
    tick();
    check("a_done_clear", done_a, 0);
    check("b_done_held", done_b, 1);
    check("a_valid_idle", valid_a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] key_a, key_b;
    int          ia, ib, a_after, cyc;
    bit          dec;

    rst_n = 1'b0; i_start = 1'b0; i_key = '0; i_decrypt = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_subkey_a", sub_a, 0);
    check("rst_round_a", round_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_done_b", done_b, 0);
    rst_n = 1'b1;
    tick();

    // Ready without valid does nothing.
    i_ready = 1'b1;
    tick();
    tick();
    check("idle_ready_valid", valid_a, 0);
    check("idle_ready_round", round_a, 0);
    i_ready = 1'b0;

    // Known-answer encrypt and decrypt.
    run_sched(KEY_REF, 1'b0, 1'b0);
    check("kat_enc_r0", got[0], 48'h1B02EFFC7072);
    check("kat_enc_r1", got[1], 48'h79AED9DBC9E5);
    check("kat_enc_r15", got[15], 48'hCB3D8B0E17F5);
    run_sched(KEY_REF, 1'b1, 1'b0);
    check("kat_dec_r0", got[0], 48'hCB3D8B0E17F5);
    check("kat_dec_r14", got[14], 48'h79AED9DBC9E5);
    check("kat_dec_r15", got[15], 48'h1B02EFFC7072);

    // Random keys under random backpressure.
    for (int t = 0; t < 4; t++) begin
      key_a = {$urandom, $urandom};
      dec   = 1'($urandom_range(0, 1));
      run_sched(key_a, dec, 1'b1);
    end

    // Degenerate keys and parity-bit insensitivity.
    run_sched(64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check("zero_key", got[i], 48'h0);
    run_sched(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) check("ones_key", got[i], 48'hFFFF_FFFF_FFFF);
    run_sched(KEY_REF ^ 64'h0101_0101_0101_0101, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) check("parity_flip", got[i], ref_key(KEY_REF, i + 1));

    // Start while busy at round 5: A ignores it, B restarts with a new key.
    key_a = {$urandom, $urandom};
    key_b = {$urandom, $urandom};
    start(key_a, 1'b0);
    i_ready = 1'b1;
    repeat (5) tick();
    check("rs_a_round5", round_a, 5);
    check("rs_b_round5", round_b, 5);
    i_key = key_b; i_decrypt = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    ia = 6; ib = 0; a_after = -1; cyc = 0;
    while (ib < 16 && cyc < 100) begin
      if (ia < 16) begin
        check("rs_a_round", round_a, ia);
        check("rs_a_subkey", sub_a, exp_sub(key_a, 1'b0, ia));
      end else begin
        check("rs_a_done", done_a, (a_after == 0) ? 1 : 0);
      end
      check("rs_b_valid", valid_b, 1);
      check("rs_b_round", round_b, ib);
      check("rs_b_subkey", sub_b, exp_sub(key_b, 1'b1, ib));
      check("rs_b_no_done", done_b, 0);
      tick();
      if (ia < 16) ia++; else a_after++;
      if (ia == 16 && a_after < 0) a_after = 0;
      ib++;
      cyc++;
    end
    i_ready = 1'b0;
    check("rs_b_transfers", ib, 16);
    check("rs_b_done", done_b, 1);
    check("rs_b_valid_end", valid_b, 0);

    // Asynchronous reset at round 7, then a fresh schedule.
    key_a = {$urandom, $urandom};
    start(key_a, 1'b0);
    i_ready = 1'b1;
    repeat (7) tick();
    check("mr_round7", round_a, 7);
    i_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid_a", valid_a, 0);
    check("mr_busy_a", busy_a, 0);
    check("mr_done_a", done_a, 0);
    check("mr_valid_b", valid_b, 0);
    check("mr_done_b", done_b, 0);
    check("mr_round_a", round_a, 0);
    check("mr_subkey_a", sub_a, 0);
    tick();
    rst_n = 1'b1;
    key_b = {$urandom, $urandom};
    dec   = 1'($urandom_range(0, 1));
    start(key_b, dec);
    check("mr_new_valid", valid_a, 1);
    check("mr_new_round", round_a, 0);
    check("mr_new_subkey", sub_a, exp_sub(key_b, dec, 0));
    check("mr_new_subkey_b", sub_b, exp_sub(key_b, dec, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
